// File: rtl/csr_pkg.sv
// Shared constants for the counter CSR unit: CSR addresses, modify-operation
// encodings, the decoded-selector enum and the read-modify-write helpers.
package csr_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;
    localparam logic [1:0] CSR_OP_SET   = 2'd2;
    localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CYC_LO,
        SEL_CYC_HI,
        SEL_INS_LO,
        SEL_INS_HI,
        SEL_INHIBIT
    } csr_sel_e;

    function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                                 input logic [31:0] old,
                                                 input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old | operand;
            CSR_OP_CLEAR: res = old & ~operand;
            default:      res = old;
        endcase
        return res;
    endfunction

    function automatic logic csr_apply_bit(input logic [1:0] op,
                                           input logic       old,
                                           input logic       operand);
        logic res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old | operand;
            CSR_OP_CLEAR: res = old & ~operand;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Counter of up to 64 bits with increment enable and 32-bit half-word
// read-modify-write; a write takes priority over the increment that cycle.
module csr_counter64
    import csr_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc_i,
    input  logic        wr_i,
    input  logic        wr_hi_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [63:0]          count_ext;
    logic [31:0]          half_old;
    logic [31:0]          half_new;
    logic [63:0]          written;

    // Bits above CNT_WIDTH read as zero and are dropped on writes.
    assign count_ext = 64'(count_q);
    assign half_old  = wr_hi_i ? count_ext[63:32] : count_ext[31:0];
    assign half_new  = csr_apply_op(op_i, half_old, wdata_i);
    assign written   = wr_hi_i ? {half_new, count_ext[31:0]}
                               : {count_ext[63:32], half_new};

    always_comb begin
        count_d = count_q;
        if (wr_i) begin
            count_d = written[CNT_WIDTH-1:0];
        end else if (inc_i) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_ext;

endmodule

// File: rtl/csr_counter.sv
// Cycle/instret counter CSR unit. Optional mcountinhibit register is enabled
// by defining CSR_COUNTER_INHIBIT_EN.
module csr_counter
    import csr_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        retired,
    input  logic        read,
    input  logic [1:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid
);

    // Handshake: a request is taken on every posedge where read=1 (no
    // backpressure). One cycle later valid=1 with rdata holding the CSR value
    // from before that edge, or valid=0/rdata=0 if the address is not ours or
    // a read-only counter was asked to modify.

    csr_sel_e    sel;
    logic        user_ro;
    logic        accept;
    logic        wr_en;
    logic        cyc_inh;
    logic        ins_inh;
    logic [31:0] inhibit_word;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;
    logic        valid_d;
    logic        valid_q;

    always_comb begin
        sel     = SEL_NONE;
        user_ro = 1'b0;
        case (addr)
            CSR_MCYCLE:               sel = SEL_CYC_LO;
            CSR_MCYCLEH:              sel = SEL_CYC_HI;
            CSR_MINSTRET:             sel = SEL_INS_LO;
            CSR_MINSTRETH:            sel = SEL_INS_HI;
            CSR_CYCLE, CSR_TIME: begin
                sel     = SEL_CYC_LO;
                user_ro = 1'b1;
            end
            CSR_CYCLEH, CSR_TIMEH: begin
                sel     = SEL_CYC_HI;
                user_ro = 1'b1;
            end
            CSR_INSTRET: begin
                sel     = SEL_INS_LO;
                user_ro = 1'b1;
            end
            CSR_INSTRETH: begin
                sel     = SEL_INS_HI;
                user_ro = 1'b1;
            end
`ifdef CSR_COUNTER_INHIBIT_EN
            CSR_MCOUNTINHIBIT:        sel = SEL_INHIBIT;
`endif
            default:                  sel = SEL_NONE;
        endcase
    end

    assign accept = read && (sel != SEL_NONE) && !(user_ro && (modify != CSR_OP_NONE));
    assign wr_en  = accept && (modify != CSR_OP_NONE);

`ifdef CSR_COUNTER_INHIBIT_EN
    logic inh_cy_q;
    logic inh_cy_d;
    logic inh_ir_q;
    logic inh_ir_d;

    always_comb begin
        inh_cy_d = inh_cy_q;
        inh_ir_d = inh_ir_q;
        if (wr_en && (sel == SEL_INHIBIT)) begin
            inh_cy_d = csr_apply_bit(modify, inh_cy_q, wdata[0]);
            inh_ir_d = csr_apply_bit(modify, inh_ir_q, wdata[2]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else begin
            inh_cy_q <= inh_cy_d;
            inh_ir_q <= inh_ir_d;
        end
    end

    assign cyc_inh      = inh_cy_q;
    assign ins_inh      = inh_ir_q;
    assign inhibit_word = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
`else
    assign cyc_inh      = 1'b0;
    assign ins_inh      = 1'b0;
    assign inhibit_word = 32'd0;
`endif

    csr_counter64 #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cycle (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (!cyc_inh),
        .wr_i    (wr_en && ((sel == SEL_CYC_LO) || (sel == SEL_CYC_HI))),
        .wr_hi_i (sel == SEL_CYC_HI),
        .op_i    (modify),
        .wdata_i (wdata),
        .count_o (cycle_cnt)
    );

    csr_counter64 #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_instret (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (retired && !ins_inh),
        .wr_i    (wr_en && ((sel == SEL_INS_LO) || (sel == SEL_INS_HI))),
        .wr_hi_i (sel == SEL_INS_HI),
        .op_i    (modify),
        .wdata_i (wdata),
        .count_o (instret_cnt)
    );

    always_comb begin
        rdata_d = 32'd0;
        valid_d = 1'b0;
        if (accept) begin
            valid_d = 1'b1;
            case (sel)
                SEL_CYC_LO:  rdata_d = cycle_cnt[31:0];
                SEL_CYC_HI:  rdata_d = cycle_cnt[63:32];
                SEL_INS_LO:  rdata_d = instret_cnt[31:0];
                SEL_INS_HI:  rdata_d = instret_cnt[63:32];
                SEL_INHIBIT: rdata_d = inhibit_word;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_csr_counter.sv
// Bench for csr_counter: reference model feeding an expected-response queue,
// directed sequences, a decode vector table and a random phase.
module tb_csr_counter;

    logic        clk;
    logic        rstn;
    logic        retired;
    logic        read;
    logic [1:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    csr_counter #(.CNT_WIDTH(64)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .retired (retired),
        .read    (read),
        .modify  (modify),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] exp_q[$];
    int          checks;
    int          errors;
    logic [63:0] m_cyc;
    logic [63:0] m_ins;
    logic        m_cy_inh;
    logic        m_ir_inh;
    logic [31:0] last_rdata;
    logic        last_valid;

    function automatic logic [31:0] op_apply(input logic [1:0] op, input logic [31:0] o,
                                             input logic [31:0] w);
        case (op)
            2'd1:    return w;
            2'd2:    return o | w;
            2'd3:    return o & ~w;
            default: return o;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        logic [32:0] exp;
        for (int i = 0; i < n; i++) begin
            rstn = 1'b0; read = 1'b0; modify = 2'd0; wdata = '0; addr = '0; retired = 1'b0;
            exp_q.push_back(33'd0);
            @(posedge clk);
            #1;
            m_cyc = '0; m_ins = '0; m_cy_inh = 1'b0; m_ir_inh = 1'b0;
            exp = exp_q.pop_front();
            checks++;
            if ({valid, rdata} !== exp) begin
                errors++;
                $display("FAIL reset_state: got %h expected %h", {valid, rdata}, exp);
            end
        end
        rstn = 1'b1;
    endtask

    // One clock: drive a request, push the model's response, then compare.
    task automatic access(input logic rd, input logic [1:0] md, input logic [31:0] wd,
                          input logic [11:0] ad, input logic rt);
        logic        hit, user_ro, acc, wr;
        logic [31:0] val, nv;
        logic [63:0] n_cyc, n_ins;
        logic        n_cy_inh, n_ir_inh;
        logic [32:0] exp, got;
        read = rd; modify = md; wdata = wd; addr = ad; retired = rt;
        hit = 1'b1; user_ro = 1'b0; val = '0;
        case (ad)
            12'hB00: val = m_cyc[31:0];
            12'hB80: val = m_cyc[63:32];
            12'hB02: val = m_ins[31:0];
            12'hB82: val = m_ins[63:32];
            12'hC00, 12'hC01: begin val = m_cyc[31:0];  user_ro = 1'b1; end
            12'hC80, 12'hC81: begin val = m_cyc[63:32]; user_ro = 1'b1; end
            12'hC02: begin val = m_ins[31:0];  user_ro = 1'b1; end
            12'hC82: begin val = m_ins[63:32]; user_ro = 1'b1; end
`ifdef CSR_COUNTER_INHIBIT_EN
            12'h320: val = {29'd0, m_ir_inh, 1'b0, m_cy_inh};
`endif
            default: hit = 1'b0;
        endcase
        acc = rd && hit && !(user_ro && md != 2'd0);
        exp_q.push_back(acc ? {1'b1, val} : 33'd0);
        wr = acc && (md != 2'd0);
        nv = op_apply(md, val, wd);
        n_cyc = m_cyc; n_ins = m_ins; n_cy_inh = m_cy_inh; n_ir_inh = m_ir_inh;
        if (wr && ad == 12'hB00)      n_cyc[31:0]  = nv;
        else if (wr && ad == 12'hB80) n_cyc[63:32] = nv;
        else if (!m_cy_inh)           n_cyc        = m_cyc + 64'd1;
        if (wr && ad == 12'hB02)      n_ins[31:0]  = nv;
        else if (wr && ad == 12'hB82) n_ins[63:32] = nv;
        else if (rt && !m_ir_inh)     n_ins        = m_ins + 64'd1;
        if (wr && ad == 12'h320) begin
            n_cy_inh = nv[0];
            n_ir_inh = nv[2];
        end
        @(posedge clk);
        #1;
        m_cyc = n_cyc; m_ins = n_ins; m_cy_inh = n_cy_inh; m_ir_inh = n_ir_inh;
        got = {valid, rdata};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL resp addr=%h md=%0d: got v=%b d=%h expected v=%b d=%h",
                     ad, md, got[32], got[31:0], exp[32], exp[31:0]);
        end
        last_valid = valid;
        last_rdata = rdata;
    endtask

    task automatic idle(input int n, input logic rt);
        for (int i = 0; i < n; i++) access(1'b0, 2'd0, 32'd0, 12'h000, rt);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  modify;
        logic [31:0] wdata;
        logic        exp_valid;
    } vec_t;

    vec_t        tab[20];
    logic [11:0] addr_pool[13];
    logic [63:0] frozen_cyc;
    logic [63:0] frozen_ins;
    logic        inh_exp;

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0; read = 1'b0; modify = '0; wdata = '0; addr = '0; retired = 1'b0;
        m_cyc = '0; m_ins = '0; m_cy_inh = 1'b0; m_ir_inh = 1'b0;
`ifdef CSR_COUNTER_INHIBIT_EN
        inh_exp = 1'b1;
`else
        inh_exp = 1'b0;
`endif
        tab[0]  = '{12'hB00, 2'd0, 32'h0, 1'b1};
        tab[1]  = '{12'hB80, 2'd0, 32'h0, 1'b1};
        tab[2]  = '{12'hB02, 2'd0, 32'h0, 1'b1};
        tab[3]  = '{12'hB82, 2'd0, 32'h0, 1'b1};
        tab[4]  = '{12'hC00, 2'd0, 32'h0, 1'b1};
        tab[5]  = '{12'hC01, 2'd0, 32'h0, 1'b1};
        tab[6]  = '{12'hC80, 2'd0, 32'h0, 1'b1};
        tab[7]  = '{12'hC81, 2'd0, 32'h0, 1'b1};
        tab[8]  = '{12'hC02, 2'd0, 32'h0, 1'b1};
        tab[9]  = '{12'hC82, 2'd0, 32'h0, 1'b1};
        tab[10] = '{12'hC00, 2'd1, 32'h1, 1'b0};
        tab[11] = '{12'hC82, 2'd2, 32'h1, 1'b0};
        tab[12] = '{12'hC81, 2'd3, 32'h1, 1'b0};
        tab[13] = '{12'h7C0, 2'd0, 32'h0, 1'b0};
        tab[14] = '{12'hB01, 2'd0, 32'h0, 1'b0};
        tab[15] = '{12'hB81, 2'd1, 32'h3, 1'b0};
        tab[16] = '{12'h320, 2'd0, 32'h0, inh_exp};
        tab[17] = '{12'hB02, 2'd1, 32'h55, 1'b1};
        tab[18] = '{12'hB80, 2'd1, 32'h7, 1'b1};
        tab[19] = '{12'hB00, 2'd2, 32'h100, 1'b1};
        addr_pool = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC01, 12'hC80,
                      12'hC81, 12'hC02, 12'hC82, 12'h320, 12'h7C0, 12'hB03};

        do_reset(2);

        idle(10, 1'b0);
        access(1'b1, 2'd0, 32'd0, 12'hC00, 1'b0);
        check32("cycle_after_reset_valid", 32'(last_valid), 32'd1);
        check32("cycle_after_reset", last_rdata, 32'd10);

        idle(5, 1'b1);
        access(1'b1, 2'd0, 32'd0, 12'hB02, 1'b0);
        check32("minstret_5", last_rdata, 32'd5);
        access(1'b1, 2'd0, 32'd0, 12'hC02, 1'b0);
        check32("instret_5", last_rdata, 32'd5);
        access(1'b1, 2'd0, 32'd0, 12'hB82, 1'b0);
        check32("minstreth_0", last_rdata, 32'd0);

        access(1'b1, 2'd1, 32'hFFFF_FFFF, 12'hB00, 1'b0);
        idle(2, 1'b0);
        access(1'b1, 2'd0, 32'd0, 12'hB80, 1'b0);
        check32("mcycleh_carry", last_rdata, 32'd1);

        access(1'b1, 2'd2, 32'h0000_00F0, 12'hB82, 1'b0);
        access(1'b1, 2'd3, 32'h0000_0010, 12'hB82, 1'b0);
        access(1'b1, 2'd0, 32'd0, 12'hB82, 1'b0);
        check32("minstreth_set_clear", last_rdata, 32'h0000_00E0);

        access(1'b1, 2'd1, 32'h1234, 12'hC00, 1'b0);
        check32("user_write_rejected", 32'(last_valid), 32'd0);
        access(1'b1, 2'd0, 32'd0, 12'hB00, 1'b0);
        access(1'b1, 2'd0, 32'd0, 12'h7C0, 1'b0);
        check32("unmapped_rejected", 32'(last_valid), 32'd0);
        access(1'b1, 2'd0, 32'd0, 12'h320, 1'b0);
        check32("inhibit_decode_valid", 32'(last_valid), 32'(inh_exp));

        // Full 64-bit wrap of cycle.
        access(1'b1, 2'd1, 32'hFFFF_FFFF, 12'hB80, 1'b0);
        access(1'b1, 2'd1, 32'hFFFF_FFFE, 12'hB00, 1'b0);
        idle(2, 1'b0);
        access(1'b1, 2'd0, 32'd0, 12'hB80, 1'b0);
        check32("cycle_wrap_hi", last_rdata, 32'd0);

`ifdef CSR_COUNTER_INHIBIT_EN
        access(1'b1, 2'd1, 32'd5, 12'h320, 1'b0);
        frozen_cyc = m_cyc;
        frozen_ins = m_ins;
        access(1'b1, 2'd0, 32'd0, 12'h320, 1'b1);
        check32("inhibit_readback", last_rdata, 32'd5);
        idle(20, 1'b1);
        access(1'b1, 2'd0, 32'd0, 12'hB00, 1'b1);
        check32("mcycle_frozen", last_rdata, frozen_cyc[31:0]);
        access(1'b1, 2'd0, 32'd0, 12'hB02, 1'b1);
        check32("minstret_frozen", last_rdata, frozen_ins[31:0]);
        access(1'b1, 2'd0, 32'd0, 12'hC01, 1'b1);
        check32("time_frozen", last_rdata, frozen_cyc[31:0]);
        access(1'b1, 2'd3, 32'd5, 12'h320, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            access(1'b1, tab[i].modify, tab[i].wdata, tab[i].addr, 1'($urandom_range(0, 1)));
            check32($sformatf("table_valid_%0d", i), 32'(last_valid), 32'(tab[i].exp_valid));
        end

        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom(),
                   addr_pool[$urandom_range(0, 12)], 1'($urandom_range(0, 1)));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_counter.md
Name: csr_counter

Overview:
- RISC-V Zicntr/machine counter CSR unit attached to the Pipeline CSR port.
- Maintains a free-running cycle counter and a retired-instruction counter, each 64 bits.
- Serves read and read-modify-write CSR accesses with a registered response.
- Answers only its own CSR addresses; every other address is left to other CSR units via valid=0.

Parameters:
- CNT_WIDTH, 64, implemented counter width (33..64); bits above CNT_WIDTH read 0 and ignore writes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- retired  in  1  one instruction retired this cycle
- read  in  1  CSR access request (read or read-modify-write)
- modify  in  2  0=none, 1=write, 2=set bits, 3=clear bits
- wdata  in  32  write/set/clear operand
- addr  in  12  CSR address
- rdata  out  32  old CSR value, registered
- valid  out  1  registered; 1 = access accepted by this unit

Behaviour:
- Reset (rstn=0 at posedge):
  - Both counters become 0.
  - rdata becomes 0 and valid becomes 0.
- Counter increments:
  - cycle increments by 1 every clock when not in reset.
  - instret increments by 1 on each clock with retired=1.
  - 64-bit wrap-around: all-ones increments to 0.
- Address map, machine read/write:
  - 0xB00 mcycle: cycle[31:0]
  - 0xB80 mcycleh: cycle[63:32]
  - 0xB02 minstret: instret[31:0]
  - 0xB82 minstreth: instret[63:32]
- Address map, user read-only:
  - 0xC00 cycle and 0xC01 time: cycle[31:0]
  - 0xC80 cycleh and 0xC81 timeh: cycle[63:32]
  - 0xC02 instret: instret[31:0]
  - 0xC82 instreth: instret[63:32]
- Access timing:
  - Request sampled when read=1 at a posedge.
  - At that edge, rdata is loaded with the pre-edge value of the addressed CSR.
  - valid is driven 1 in the cycle after the request; latency is exactly 1 cycle.
  - When read=0: valid becomes 0 and rdata becomes 0.
- valid=0 (access rejected, counters unchanged) for:
  - an unimplemented address;
  - modify≠0 on a 0xC.. address; the core raises illegal-instruction.
- Accepted write to a machine address:
  - New half = wdata (modify=1), old|wdata (2), or old&~wdata (3).
  - The other half keeps its old value.
  - The written counter does not increment that cycle, even if retired=1; no carry is generated.
  - The other counter increments normally.
- Back-to-back requests are allowed every cycle.
- Read after write (next cycle) returns the written value plus any increments since.

Optional Feature:
- Macro CSR_COUNTER_INHIBIT_EN.
- When defined, adds mcountinhibit at 0x320, read/write via the same modify rules.
  - Bit 0 (CY) freezes cycle; bit 2 (IR) freezes instret.
  - All other bits read 0; reset value is 0.
  - time/timeh follow cycle, including the freeze.
- When undefined, 0x320 returns valid=0 and counters never stop.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants, e.g. CSR_MCYCLE=12'hB00 and CSR_MCOUNTINHIBIT=12'h320;
  - modify encoding constants: CSR_OP_NONE, CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR.
- One natural sub-module, csr_counter64: a 64-bit counter with enable and half-word write.
  - Instantiated twice, for cycle and instret.
- Address decode and the read mux live in the top level.

Test Plan:
- Reset, then hold rstn=1 for 10 cycles; read 0xC00 → valid=1 next cycle, rdata=10 (±1 per the decided sampling point, checked exactly against the model).
- Pulse retired 5 times, then read 0xB02 → rdata=5; read 0xC02 → rdata=5; read 0xB82 → rdata=0.
- Write 0xB00 with 0xFFFFFFFF (modify=1), then wait 2 cycles and read 0xB80 → rdata=1, confirming carry into the high half.
- Set 0xB82 with 0x00F0 (modify=2), then clear with 0x0010 (modify=3), then read → 0x000000E0.
- modify=1 to 0xC00 → valid=0 and cycle unaffected; read 0x7C0 → valid=0.
- With CSR_COUNTER_INHIBIT_EN: write 0x320=5, idle with retired=1 for 20 cycles, then read mcycle and minstret → both unchanged.
